// File: rtl/sort_engine_pingpong.sv
// ---------------------------------------------------------------------------
// sort_engine_pingpong
//
// Double-buffered packet sorter. Each packet is insertion-sorted into one of
// two register banks as it arrives (one word per cycle). The sorted packet is
// then streamed out of that bank while the other bank fills. Sort direction
// is chosen per packet. Words beyond MAX_LEN are dropped, and the overflow is
// flagged on the last output word.
//
// Ports:
//   clk_i        clock
//   rst_n_i      asynchronous active-low reset
//   pkt_i_data   input word (key, compared unsigned)
//   pkt_i_val    input word valid
//   pkt_i_sop    input first word (informational)
//   pkt_i_eop    input last word, closes the packet
//   pkt_i_desc   sort direction, sampled with the first word (1 = descending)
//   pkt_i_ready  input accept (depends on bank state only)
//   pkt_o_data   sorted output word
//   pkt_o_val    output valid
//   pkt_o_sop    first sorted word
//   pkt_o_eop    last sorted word
//   pkt_o_err    overflow flag, qualified by pkt_o_eop
//   pkt_o_len    stored word count, qualified by pkt_o_val
//   pkt_o_ready  output accept
// ---------------------------------------------------------------------------
module sort_engine_pingpong #(
    parameter int DWIDTH  = 8,
    parameter int MAX_LEN = 32,
    parameter int LWIDTH  = $clog2(MAX_LEN + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DWIDTH-1:0] pkt_i_data,
    input  logic              pkt_i_val,
    input  logic              pkt_i_sop,
    input  logic              pkt_i_eop,
    input  logic              pkt_i_desc,
    output logic              pkt_i_ready,
    output logic [DWIDTH-1:0] pkt_o_data,
    output logic              pkt_o_val,
    output logic              pkt_o_sop,
    output logic              pkt_o_eop,
    output logic              pkt_o_err,
    output logic [LWIDTH-1:0] pkt_o_len,
    input  logic              pkt_o_ready
);

    localparam int IWIDTH = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {FREE, FILL, FULL, DRAIN} bank_st_t;

    // True when a stored key must move behind the incoming key. Strict
    // comparison keeps equal keys in arrival order.
    function automatic logic key_after(input logic [DWIDTH-1:0] key,
                                       input logic [DWIDTH-1:0] din,
                                       input logic              dsc);
        return dsc ? (key < din) : (key > din);
    endfunction

    // Stored count saturates at MAX_LEN; overflow words are dropped.
    function automatic logic [LWIDTH-1:0] cnt_inc_sat(input logic [LWIDTH-1:0] c);
        return (c == LWIDTH'(MAX_LEN)) ? c : c + LWIDTH'(1);
    endfunction

    // Bank control
    bank_st_t          st     [2];
    bank_st_t          st_nxt [2];
    logic [LWIDTH-1:0] cnt    [2];
    logic [1:0]        err_b;
    logic [1:0]        desc_b;
    logic              wr_sel;
    logic              rd_sel;
    logic [LWIDTH-1:0] rd_idx;

    // Bank storage (data only, never reset)
    logic [DWIDTH-1:0] mem [2][MAX_LEN];

    // Write side
    logic               wr_en;
    logic               room;
    logic               cur_desc;
    logic [LWIDTH-1:0]  cur_cnt;
    logic [MAX_LEN-1:0] gt;
    logic [DWIDTH-1:0]  ins_row [MAX_LEN];

    // Read side
    logic              finishing;
    logic              out_adv;
    logic              ld_ok;
    logic              ld_last;
    logic              ld_bank;
    logic              nb;
    logic [LWIDTH-1:0] ld_idx;

    // Output register stage
    logic              vld_p1;
    logic              sop_p1;
    logic              eop_p1;
    logic              err_p1;
    logic [DWIDTH-1:0] data_p1;
    logic [LWIDTH-1:0] len_p1;

    // Packet start is inferred from the bank state, so sop carries no logic.
    logic unused_sop;
    assign unused_sop = pkt_i_sop;

    assign pkt_i_ready = (st[wr_sel] == FREE) || (st[wr_sel] == FILL);

    // ---- stage p0: insertion into the write bank ----
    always_comb begin
        cur_cnt  = (st[wr_sel] == FREE) ? '0 : cnt[wr_sel];
        cur_desc = (st[wr_sel] == FREE) ? pkt_i_desc : desc_b[wr_sel];
        wr_en    = pkt_i_val && pkt_i_ready;
        room     = cur_cnt < LWIDTH'(MAX_LEN);
        gt       = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            gt[i] = (LWIDTH'(i) < cur_cnt) &&
                    key_after(mem[wr_sel][i], pkt_i_data, cur_desc);
        end
        // The bank is always sorted, so gt is a contiguous run ending at
        // cur_cnt-1: entries at and above the first set bit shift up by one,
        // and the new word lands at that first set bit (or at cur_cnt).
        ins_row[0] = (gt[0] || (cur_cnt == '0)) ? pkt_i_data : mem[wr_sel][0];
        for (int i = 1; i < MAX_LEN; i++) begin
            if (gt[i-1]) begin
                ins_row[i] = mem[wr_sel][i-1];
            end else if (gt[i] || (LWIDTH'(i) == cur_cnt)) begin
                ins_row[i] = pkt_i_data;
            end else begin
                ins_row[i] = mem[wr_sel][i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && room) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                mem[wr_sel][i] <= ins_row[i];
            end
        end
    end

    // Read-side selection. When the current packet's eop handshake completes
    // and the partner bank is already FULL, its first word is loaded on the
    // same edge so the two packets leave back-to-back.
    always_comb begin
        nb        = ~rd_sel;
        finishing = vld_p1 && eop_p1 && pkt_o_ready;
        out_adv   = !vld_p1 || pkt_o_ready;
        if (finishing) begin
            ld_bank = nb;
            ld_idx  = '0;
            ld_ok   = (st[nb] == FULL);
        end else begin
            ld_bank = rd_sel;
            ld_idx  = rd_idx;
            ld_ok   = out_adv && (st[rd_sel] == DRAIN) && (rd_idx < cnt[rd_sel]);
        end
        ld_last = (ld_idx + LWIDTH'(1)) == cnt[ld_bank];
    end

    always_comb begin
        st_nxt[0] = st[0];
        st_nxt[1] = st[1];
        if (wr_en) begin
            if (st[wr_sel] == FREE) begin
                st_nxt[wr_sel] = FILL;
            end
            if (pkt_i_eop) begin
                st_nxt[wr_sel] = FULL;
            end
        end
        if (finishing) begin
            st_nxt[rd_sel] = FREE;
            if (st[nb] == FULL) begin
                st_nxt[nb] = DRAIN;
            end
        end else if (st[rd_sel] == FULL) begin
            // Output idle: claim the bank now, first word loads next edge.
            st_nxt[rd_sel] = DRAIN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            st[0]  <= FREE;
            st[1]  <= FREE;
            cnt[0] <= '0;
            cnt[1] <= '0;
            err_b  <= '0;
            desc_b <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            rd_idx <= '0;
        end else begin
            st[0] <= st_nxt[0];
            st[1] <= st_nxt[1];
            if (wr_en) begin
                if (st[wr_sel] == FREE) begin
                    desc_b[wr_sel] <= pkt_i_desc;
                    err_b[wr_sel]  <= 1'b0;
                end
                cnt[wr_sel] <= cnt_inc_sat(cur_cnt);
                if (!room) begin
                    err_b[wr_sel] <= 1'b1;
                end
                if (pkt_i_eop) begin
                    wr_sel <= ~wr_sel;
                end
            end
            if (finishing) begin
                cnt[rd_sel] <= '0;
                rd_sel      <= ~rd_sel;
                rd_idx      <= ld_ok ? LWIDTH'(1) : '0;
            end else if (ld_ok) begin
                rd_idx <= rd_idx + LWIDTH'(1);
            end
        end
    end

    // ---- stage p1: registered output ----
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_p1  <= 1'b0;
            sop_p1  <= 1'b0;
            eop_p1  <= 1'b0;
            err_p1  <= 1'b0;
            data_p1 <= '0;
            len_p1  <= '0;
        end else if (out_adv) begin
            vld_p1 <= ld_ok;
            if (ld_ok) begin
                data_p1 <= mem[ld_bank][ld_idx[IWIDTH-1:0]];
                sop_p1  <= (ld_idx == '0);
                eop_p1  <= ld_last;
                err_p1  <= ld_last && err_b[ld_bank];
                len_p1  <= cnt[ld_bank];
            end else begin
                sop_p1 <= 1'b0;
                eop_p1 <= 1'b0;
                err_p1 <= 1'b0;
            end
        end
    end

    assign pkt_o_val  = vld_p1;
    assign pkt_o_sop  = sop_p1;
    assign pkt_o_eop  = eop_p1;
    assign pkt_o_err  = err_p1;
    assign pkt_o_data = data_p1;
    assign pkt_o_len  = len_p1;

endmodule
